// File: rtl/uart_tx_feeder_pkg.sv
// rtl/uart_tx_feeder_pkg.sv - shared widths, default depth and FSM states for the uart_tx feeder
package uart_tx_feeder_pkg;

  localparam int WORD_W        = 16;
  localparam int BYTE_W        = 8;
  localparam int DEFAULT_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_ACK,
    ST_WAIT_DONE
  } state_t;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// rtl/uart_tx_feeder_if.sv - producer word handshake plus uart_tx byte handshake bundle
interface uart_tx_feeder_if #(
  parameter int CW = 4
);
  import uart_tx_feeder_pkg::*;

  logic [WORD_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic [CW-1:0]     level;
  logic              idle;

  modport master (
    output wr_data, wr_valid, tx_busy,
    input  wr_ready, tx_data, tx_start, level, idle
  );

  modport slave (
    input  wr_data, wr_valid, tx_busy,
    output wr_ready, tx_data, tx_start, level, idle
  );

endinterface

// File: rtl/uart_tx_feeder_fifo.sv
// rtl/uart_tx_feeder_fifo.sv - circular word FIFO with registered full flag and fill level
module word_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    level_q, level_d;
  logic             full_q, full_d;
  logic             do_push, do_pop;

  // Pointers are exactly AW bits wide, so the power-of-two depth makes them wrap for free.
  always_comb begin
    do_push  = push_i && !full_q;
    do_pop   = pop_i && (level_q != '0);
    wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, do_pop};
    level_d  = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + 1'b1;
    end else if (do_pop && !do_push) begin
      level_d = level_q - 1'b1;
    end
    full_d = (level_d == CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - buffers 16-bit words and hands them to uart_tx as high byte then low byte
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_feeder_if.slave   bus
);

  logic [1:0]        rst_sync_q;
  logic              rst_n_int;
  state_t            state_q, state_d;
  logic              byte_sel_q, byte_sel_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              pop;
  logic [WORD_W-1:0] fifo_dout;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_level;

  // Reset asserts immediately but releases two clocks later, aligned to clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync_q[1];

  word_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n_int),
    .push_i  (bus.wr_valid),
    .din_i   (bus.wr_data),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q    <= ST_IDLE;
      byte_sel_q <= 1'b0;
      hold_q     <= '0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      byte_sel_q <= byte_sel_d;
      hold_q     <= hold_d;
      tx_data_q  <= tx_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_sel_d = byte_sel_q;
    hold_d     = hold_q;
    tx_data_d  = tx_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pop) begin
          hold_d     = fifo_dout;
          byte_sel_d = 1'b0;
          tx_data_d  = fifo_dout[WORD_W-1:BYTE_W];
          state_d    = ST_START;
        end
      end
      ST_START: begin
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (bus.tx_busy) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (!byte_sel_q) begin
            byte_sel_d = 1'b1;
            tx_data_d  = hold_q[BYTE_W-1:0];
            state_d    = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A leftover busy from a byte launched before reset holds off the next launch.
  always_comb begin
    pop          = (state_q == ST_IDLE) && !fifo_empty && !bus.tx_busy;
    bus.tx_start = (state_q == ST_START);
    bus.idle     = fifo_empty && (state_q == ST_IDLE) && !bus.tx_busy;
    bus.wr_ready = !fifo_full;
    bus.tx_data  = tx_data_q;
    bus.level    = fifo_level;
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - directed bench for uart_tx_feeder with a behavioural uart_tx busy model
module tb_uart_tx_feeder;

  typedef logic [7:0] byte_q_t[$];

  localparam int BOUND    = 3000;
  localparam int BUSY_LEN = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  byte_q_t got;
  int      start_cnt     = 0;
  int      start_in_busy = 0;
  bit      force_busy    = 1'b0;
  int      ack_delay     = 0;
  bit      armed         = 1'b0;
  int      ack_wait      = 0;
  int      busy_cnt      = 0;

  uart_tx_feeder_if #(.CW(4)) bus ();

  uart_tx_feeder #(
    .DEPTH (8),
    .CW    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // uart_tx stand-in: captures start, raises busy after ack_delay+1 cycles, holds it BUSY_LEN cycles.
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        bus.tx_busy = 1'b0;
        armed       = 1'b0;
        busy_cnt    = 0;
      end else if (force_busy) begin
        bus.tx_busy = 1'b1;
      end else begin
        if (bus.tx_busy) begin
          if (busy_cnt > 0) busy_cnt--;
          if (busy_cnt == 0) bus.tx_busy = 1'b0;
        end else if (armed) begin
          if (ack_wait == 0) begin
            bus.tx_busy = 1'b1;
            busy_cnt    = BUSY_LEN;
            armed       = 1'b0;
          end else begin
            ack_wait--;
          end
        end
        if (bus.tx_start) begin
          if (bus.tx_busy) start_in_busy++;
          got.push_back(bus.tx_data);
          start_cnt++;
          armed    = 1'b1;
          ack_wait = ack_delay;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_stream(input string tag, input byte_q_t exp);
    chk({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      chk($sformatf("%s_b%0d", tag, i), {24'h0, got[i]}, {24'h0, exp[i]});
    end
    got.delete();
  endtask

  task automatic push_word(input logic [15:0] w);
    int n = 0;
    bus.wr_data  = w;
    bus.wr_valid = 1'b1;
    while (!bus.wr_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (n >= BOUND) chk("push_timeout", 32'(n), 32'(BOUND - 1));
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!bus.idle && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, {31'h0, bus.idle}, 32'h1);
  endtask

  initial begin
    byte_q_t e;
    int      pulses;

    bus.wr_data  = '0;
    bus.wr_valid = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_level", 32'(bus.level), 32'h0);
    chk("rst_wr_ready", {31'h0, bus.wr_ready}, 32'h1);
    chk("rst_idle", {31'h0, bus.idle}, 32'h1);
    chk("rst_tx_start", {31'h0, bus.tx_start}, 32'h0);
    chk("rst_tx_data", {24'h0, bus.tx_data}, 32'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // single word, latency and byte order
    push_word(16'hA55A);
    chk("lat_start_early", {31'h0, bus.tx_start}, 32'h0);
    chk("lat_level1", 32'(bus.level), 32'h1);
    @(negedge clk);
    chk("lat_start", {31'h0, bus.tx_start}, 32'h1);
    chk("lat_data_hi", {24'h0, bus.tx_data}, 32'hA5);
    chk("lat_level0", 32'(bus.level), 32'h0);
    wait_idle("single");
    chk("single_data_lo", {24'h0, bus.tx_data}, 32'h5A);
    e = {8'hA5, 8'h5A};
    check_stream("single", e);

    // fill against a stalled uart_tx
    force_busy = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 8; i++) begin
      push_word(16'(i));
      if (i == 7) chk("fill_ready7", {31'h0, bus.wr_ready}, 32'h1);
    end
    chk("fill_ready8", {31'h0, bus.wr_ready}, 32'h0);
    chk("fill_level8", 32'(bus.level), 32'h8);
    bus.wr_data  = 16'h0009;
    bus.wr_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("fill_held_ready", {31'h0, bus.wr_ready}, 32'h0);
    chk("fill_held_level", 32'(bus.level), 32'h8);
    force_busy = 1'b0;
    push_word(16'h0009);
    wait_idle("fill");
    e = {};
    for (int i = 1; i <= 9; i++) begin
      e.push_back(8'h00);
      e.push_back(8'(i));
    end
    check_stream("fill", e);

    // simultaneous push and pop at level 3
    force_busy = 1'b1;
    @(negedge clk);
    push_word(16'h3101);
    push_word(16'h3202);
    push_word(16'h3303);
    chk("pp_level3", 32'(bus.level), 32'h3);
    force_busy = 1'b0;
    @(negedge clk);
    bus.wr_data  = 16'h3404;
    bus.wr_valid = 1'b1;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    chk("pp_level_kept", 32'(bus.level), 32'h3);
    chk("pp_start", {31'h0, bus.tx_start}, 32'h1);
    chk("pp_oldest", {24'h0, bus.tx_data}, 32'h31);
    wait_idle("pp");
    e = {8'h31, 8'h01, 8'h32, 8'h02, 8'h33, 8'h03, 8'h34, 8'h04};
    check_stream("pp", e);

    // wrap-around stream
    for (int i = 0; i < 20; i++) push_word(16'h1000 + 16'(i));
    wait_idle("wrap");
    e = {};
    for (int i = 0; i < 20; i++) begin
      e.push_back(8'h10);
      e.push_back(8'(i));
    end
    check_stream("wrap", e);

    // slow acknowledge from uart_tx
    ack_delay = 5;
    push_word(16'h7E81);
    @(negedge clk);
    chk("ack_start", {31'h0, bus.tx_start}, 32'h1);
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.tx_start) pulses++;
    end
    chk("ack_no_repulse", 32'(pulses), 32'h0);
    chk("ack_busy_low", {31'h0, bus.tx_busy}, 32'h0);
    wait_idle("ack");
    ack_delay = 0;
    e = {8'h7E, 8'h81};
    check_stream("ack", e);

    // reset during the high byte with four words queued
    push_word(16'hD0D1);
    repeat (2) @(negedge clk);
    force_busy = 1'b1;
    for (int i = 1; i <= 4; i++) push_word(16'hE000 + 16'(i));
    chk("mid_level4", 32'(bus.level), 32'h4);
    chk("mid_sent", 32'(got.size()), 32'h1);
    rst = 1'b0;
    #1;
    chk("mid_rst_level", 32'(bus.level), 32'h0);
    chk("mid_rst_start", {31'h0, bus.tx_start}, 32'h0);
    chk("mid_rst_ready", {31'h0, bus.wr_ready}, 32'h1);
    chk("mid_rst_data", {24'h0, bus.tx_data}, 32'h0);
    repeat (3) @(negedge clk);
    force_busy = 1'b0;
    rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("mid_no_low", 32'(got.size()), 32'h1);
    chk("mid_idle", {31'h0, bus.idle}, 32'h1);
    push_word(16'hBEEF);
    wait_idle("mid");
    e = {8'hD0, 8'hBE, 8'hEF};
    check_stream("mid", e);

    chk("start_vs_busy", 32'(start_in_busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 Parameter: DEPTH, default 8, word-FIFO depth; power of two, minimum 2.
REQ-002 Parameter: CW, default $clog2(DEPTH)+1, width of the fill-level count.
REQ-003 clk  input  1  single clock for all state; the same clock drives the downstream uart_tx.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 wr_data  input  16  matrix result word to be transmitted.
REQ-006 wr_valid  input  1  producer has a word on wr_data.
REQ-007 wr_ready  output  1  FIFO can accept a word.
REQ-008 tx_data  output  8  byte presented to uart_tx data.
REQ-009 tx_start  output  1  one-cycle launch pulse to uart_tx start.
REQ-010 tx_busy  input  1  uart_tx busy.
REQ-011 level  output  CW  number of words held in the FIFO; excludes the word in flight.
REQ-012 idle  output  1  high when the FIFO is empty, the FSM is in IDLE and tx_busy is low.

Function
REQ-013 A word is accepted on a rising clk edge only when wr_valid and wr_ready are both high; wr_data is not sampled otherwise.
REQ-014 wr_ready equals the inverse of the registered full flag.
  - A pop in the same cycle does not raise wr_ready combinationally.
REQ-015 The FIFO is circular, with wr_ptr and rd_ptr that wrap modulo DEPTH.
  - level increments on a push, decrements on a pop, and is unchanged on a simultaneous push and pop.
REQ-016 Each word is sent as two bytes, high byte [15:8] first, then low byte [7:0].
REQ-017 The FSM has four states: IDLE, START, WAIT_ACK and WAIT_DONE, plus a 1-bit byte_sel.
REQ-018 IDLE: when the FIFO is non-empty, pop one word into a 16-bit hold register, clear byte_sel, and go to START.
  - Otherwise stay in IDLE.
REQ-019 START: tx_start is high for exactly this one cycle, and the FSM goes to WAIT_ACK.
REQ-020 WAIT_ACK: stay while tx_busy is low; go to WAIT_DONE when tx_busy is high.
  - This covers uart_tx raising busy one cycle after the start pulse.
REQ-021 WAIT_DONE: stay while tx_busy is high. When tx_busy is low:
  - if byte_sel is 0, set byte_sel to 1 and go to START;
  - if byte_sel is 1, go to IDLE.
REQ-022 tx_data is the hold register's high byte when byte_sel is 0 and its low byte when byte_sel is 1.
  - tx_data is registered and is stable from START until the FSM leaves WAIT_DONE.
REQ-023 Latency: a word pushed into an empty FIFO with the FSM in IDLE at edge N gives tx_start high in cycle N+2.
REQ-024 The FSM does not pop while a word is in flight; pushes continue freely until the FIFO is full.
REQ-025 A push while full is ignored (wr_ready is low); there is no overflow and no data corruption.
REQ-026 No pop occurs while the FIFO is empty; the FSM holds in IDLE.
REQ-027 tx_start never asserts while tx_busy is high.

Reset
REQ-028 While rst is low:
  - pointers and level are 0; the FIFO is empty;
  - the FSM is in IDLE and byte_sel is 0;
  - tx_start is 0, tx_data is 8'h00, wr_ready is 1 and idle is 1.
REQ-029 A reset asserted mid-transfer discards the FIFO contents and the word in flight.
  - Any byte already launched in uart_tx is not tracked; after release the FSM restarts from IDLE.
REQ-030 Reset assertion is asynchronous; deassertion is taken synchronously through a two-flop release synchronizer.

Structure
REQ-031 A shared package holds:
  - the FSM state enumeration;
  - the word width (16) and byte width (8) constants;
  - the default DEPTH.
REQ-032 The FIFO is one sub-module, word_fifo (parameters DEPTH and width), instantiated once; the FSM and byte mux live in uart_tx_feeder.

Verification
REQ-033 Single word: push 16'hA55A into an empty FIFO while tx_busy is low.
  - tx_start pulses at N+2 with tx_data 8'hA5.
  - A second tx_start follows after the first busy falls, with tx_data 8'h5A.
  - idle returns to 1 at the end.
REQ-034 Fill: push 9 words 16'h0001..16'h0009 back-to-back with DEPTH=8 and uart_tx stalled.
  - wr_ready drops after the 8th push; the 9th word is held by the producer.
  - The byte stream is 00 01 00 02 ... 00 08, then 00 09.
REQ-035 Simultaneous push and pop with level=3: level stays 3 and the next pop returns the oldest word.
REQ-036 Wrap-around: stream 20 words 16'h1000+i through DEPTH=8; all 40 bytes arrive in order with none lost.
REQ-037 Handshake: tx_busy is held low for 5 cycles after tx_start.
  - The FSM stays in WAIT_ACK; tx_start is not re-pulsed.
  - When busy rises then falls, the low byte is launched.
REQ-038 Reset mid-transfer: assert rst during WAIT_DONE of the high byte with level=4.
  - level goes to 0, tx_start stays 0 and no low byte is sent.
  - After release, a new word 16'hBEEF sends BE then EF.
